// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA3 message padder.
package sha3_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  localparam logic [7:0] PAD_SHA3 = 8'h06;
  localparam logic [7:0] PAD_END  = 8'h80;

  function automatic int rate_bits(input int d);
    return 1600 - 2 * d;
  endfunction

endpackage

// File: rtl/sha3_padder.sv
// Byte-serial SHA3 padder: packs message bytes into rate blocks and appends pad10*1.
// Optional build macro SHA3_PADDER_COUNT_EN adds the msg_len byte counter output.
module sha3_padder
  import sha3_pkg::*;
#(
  parameter int         D      = 256,
  parameter logic [7:0] DOMAIN = PAD_SHA3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  input  logic                      in_last,
  input  logic                      flush,
  output logic                      in_ready,
  output logic [rate_bits(D)-1:0]   block,
  output logic                      block_valid,
  output logic                      block_last,
  input  logic                      block_ready
`ifdef SHA3_PADDER_COUNT_EN
  ,
  output logic [31:0]               msg_len
`endif
);

  localparam int R  = rate_bits(D);
  localparam int NB = R / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int BW = $clog2(R);

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [R-1:0]    r_block;
  logic            r_last;
  logic            r_pend;

  logic [CW-1:0]   w_cnt_nxt;
  logic            w_full;
  logic [BW-1:0]   w_pos;
  logic [R-1:0]    w_pad;

  // Byte index 0 lives in the top byte of the block.
  assign w_pos     = BW'(R - 8) - BW'({r_cnt, 3'b000});
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_full    = (w_cnt_nxt == CW'(NB));

  // Bytes beyond cnt are already zero, so only the domain byte and end bit are added.
  always_comb begin
    w_pad            = r_block;
    w_pad[w_pos +: 8] = DOMAIN;
    w_pad[7:0]       = w_pad[7:0] | PAD_END;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
      r_block <= '0;
      r_last  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (in_valid) begin
            r_block[w_pos +: 8] <= in_data;
            r_cnt               <= w_cnt_nxt;
            if (w_full) begin
              r_state <= ST_EMIT;
              r_pend  <= in_last;
            end else if (in_last) begin
              r_state <= ST_PAD;
            end
          end else if (flush) begin
            r_state <= ST_PAD;
          end
        end
        ST_PAD: begin
          r_block <= w_pad;
          r_last  <= 1'b1;
          r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (block_ready) begin
            r_cnt   <= '0;
            r_block <= '0;
            r_last  <= 1'b0;
            if (r_pend) begin
              r_pend  <= 1'b0;
              r_state <= ST_PAD;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_FILL);
  assign block_valid = (r_state == ST_EMIT);
  assign block_last  = r_last;
  assign block       = r_block;

`ifdef SHA3_PADDER_COUNT_EN
  logic [31:0] r_msg_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_msg_len <= '0;
    end else if (r_state == ST_FILL && in_valid) begin
      if (r_msg_len != 32'hFFFF_FFFF) r_msg_len <= r_msg_len + 32'd1;
    end else if (r_state == ST_EMIT && block_ready && r_last) begin
      r_msg_len <= '0;
    end
  end

  assign msg_len = r_msg_len;
`endif

endmodule

// File: tb/tb_sha3_padder.sv
// Directed bench for sha3_padder (D=256): padding, alignment, stalls and reset recovery.
module tb_sha3_padder;

  localparam int R  = 1088;
  localparam int NB = 136;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         flush = 1'b0;
  logic         block_ready = 1'b0;
  logic         in_ready;
  logic [R-1:0] block;
  logic         block_valid;
  logic         block_last;
`ifdef SHA3_PADDER_COUNT_EN
  logic [31:0]  msg_len;
`endif

  int           checks = 0;
  int           errors = 0;
  logic [R-1:0] eb;
  logic [R-1:0] got;
  logic [R-1:0] snap;
  logic         got_last;
  logic [7:0]   m300 [300];
  int           nblk;

  always #5 clk = ~clk;

  sha3_padder #(.D(256), .DOMAIN(8'h06)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .flush       (flush),
    .in_ready    (in_ready),
    .block       (block),
    .block_valid (block_valid),
    .block_last  (block_last),
    .block_ready (block_ready)
`ifdef SHA3_PADDER_COUNT_EN
    ,
    .msg_len     (msg_len)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [R-1:0] obs, input logic [R-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs hi=%h lo=%h exp hi=%h lo=%h", tag,
             obs[R-1:R-64], obs[63:0], exp[R-1:R-64], exp[63:0]);
    end
  endtask

  task automatic put(input int idx, input logic [7:0] v);
    eb[R-1-8*idx -: 8] = v;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    @(negedge clk);
    if (!in_ready) wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    if (!in_ready) wait_ready();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic take(output logic [R-1:0] b, output logic l);
    int n = 0;
    @(negedge clk);
    while (!block_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("valid_wait", {63'd0, block_valid}, 64'd1);
    b = block;
    l = block_last;
    block_ready = 1'b1;
    @(posedge clk);
    #1;
    block_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'd0, block_valid}, 64'd0);
    chk("rst_last", {63'd0, block_last}, 64'd0);
    chk_blk("rst_block", block, '0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
`ifdef SHA3_PADDER_COUNT_EN
    chk("rst_len", {32'd0, msg_len}, 64'd0);
`endif

    // block_ready with nothing to emit is ignored
    block_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rdy_valid", {63'd0, block_valid}, 64'd0);
    chk("idle_rdy_inrdy", {63'd0, in_ready}, 64'd1);
    block_ready = 1'b0;

    // Empty message
    do_flush();
    chk("empty_pad_valid", {63'd0, block_valid}, 64'd0);
    chk("empty_pad_inrdy", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("empty_lat2", {63'd0, block_valid}, 64'd1);
    eb = '0; put(0, 8'h06); put(135, 8'h80);
    chk_blk("empty_block", block, eb);
    chk("empty_last", {63'd0, block_last}, 64'd1);
    take(got, got_last);
    @(negedge clk);
    chk("empty_back_fill", {63'd0, in_ready}, 64'd1);
    chk("empty_back_valid", {63'd0, block_valid}, 64'd0);

    // "abc"
    send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b1);
`ifdef SHA3_PADDER_COUNT_EN
    chk("abc_len", {32'd0, msg_len}, 64'd3);
`endif
    take(got, got_last);
    chk("abc_hi", {32'd0, got[R-1:R-32]}, 64'h61626306);
    chk("abc_lo", {56'd0, got[7:0]}, 64'h80);
    eb = '0; put(0, 8'h61); put(1, 8'h62); put(2, 8'h63); put(3, 8'h06); put(135, 8'h80);
    chk_blk("abc_block", got, eb);
    chk("abc_last", {63'd0, got_last}, 64'd1);
`ifdef SHA3_PADDER_COUNT_EN
    chk("abc_len_clr", {32'd0, msg_len}, 64'd0);
`endif

    // 135 bytes: single merged pad byte 0x86
    eb = '0;
    for (int i = 0; i < 135; i++) begin
      send(8'(i + 1), i == 134);
      put(i, 8'(i + 1));
    end
    put(135, 8'h86);
    take(got, got_last);
    chk("b135_lo", {56'd0, got[7:0]}, 64'h86);
    chk_blk("b135_block", got, eb);
    chk("b135_last", {63'd0, got_last}, 64'd1);

    // 136 bytes: data block, then pure pad block
    eb = '0;
    for (int i = 0; i < 136; i++) begin
      send(8'(255 - i), i == 135);
      put(i, 8'(255 - i));
    end
    chk("b136_lat1", {63'd0, block_valid}, 64'd1);
    chk("b136_inrdy", {63'd0, in_ready}, 64'd0);
    take(got, got_last);
    chk_blk("b136_blk1", got, eb);
    chk("b136_last1", {63'd0, got_last}, 64'd0);
    chk("b136_pad_cycle", {63'd0, block_valid}, 64'd0);
    take(got, got_last);
    eb = '0; put(0, 8'h06); put(135, 8'h80);
    chk_blk("b136_blk2", got, eb);
    chk("b136_last2", {63'd0, got_last}, 64'd1);

    // 300 bytes with a 5-cycle downstream stall on the first block
    for (int i = 0; i < 300; i++) m300[i] = 8'(i * 7 + 3);
    nblk = 0;
    for (int i = 0; i < 300; i++) begin
      send(m300[i], i == 299);
      if (block_valid) begin
        if (nblk == 0) begin
          snap = block;
          repeat (5) begin
            @(negedge clk);
            chk_blk("stall_hold", block, snap);
            chk("stall_inrdy", {63'd0, in_ready}, 64'd0);
            chk("stall_valid", {63'd0, block_valid}, 64'd1);
          end
        end
        take(got, got_last);
        eb = '0;
        for (int j = 0; j < NB; j++) put(j, m300[nblk * NB + j]);
        chk_blk("m300_data", got, eb);
        chk("m300_data_last", {63'd0, got_last}, 64'd0);
        nblk++;
      end
    end
    take(got, got_last);
    nblk++;
    eb = '0;
    for (int j = 0; j < 28; j++) put(j, m300[272 + j]);
    put(28, 8'h06); put(135, 8'h80);
    chk_blk("m300_tail", got, eb);
    chk("m300_tail_last", {63'd0, got_last}, 64'd1);
    chk("m300_nblk", 64'(nblk), 64'd3);

    // Reset mid-message discards it
    for (int i = 0; i < 50; i++) send(8'(i ^ 8'h5A), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, block_valid}, 64'd0);
    chk_blk("mid_rst_block", block, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_inrdy", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_nvalid", {63'd0, block_valid}, 64'd0);
    send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b1);
`ifdef SHA3_PADDER_COUNT_EN
    @(negedge clk);
    chk("rst_abc_len", {32'd0, msg_len}, 64'd3);
`endif
    take(got, got_last);
    eb = '0; put(0, 8'h61); put(1, 8'h62); put(2, 8'h63); put(3, 8'h06); put(135, 8'h80);
    chk_blk("rst_abc_block", got, eb);
    chk("rst_abc_last", {63'd0, got_last}, 64'd1);

    // in_valid together with flush: the byte wins, the flush is dropped
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h61; in_last = 1'b0; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("vf_inrdy", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("vf_novalid", {63'd0, block_valid}, 64'd0);
    send(8'h62, 1'b0); send(8'h63, 1'b1);
    take(got, got_last);
    chk_blk("vf_block", got, eb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha3_padder.md
SHA3_PADDER -- requirements
Module: sha3_padder

Interface
REQ-001 SHALL have parameter D, default 256, digest length in bits; legal values 224, 256, 384, 512.
REQ-002 SHALL have parameter DOMAIN, default 8'h06, the domain-separation byte (the SHA3 value).
REQ-003 SHALL derive localparam R = 1600-2*D (rate in bits) and NB = R/8 (bytes per block).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  byte available on in_data.
REQ-007 in_data  input  8  message byte.
REQ-008 in_last  input  1  qualifies in_valid; this byte ends the message.
REQ-009 flush  input  1  ends the current message without supplying a byte; required for empty or byte-aligned message ends.
REQ-010 in_ready  output  1  byte/flush accepted when high with in_valid/flush.
REQ-011 block  output  R  assembled rate block; first byte in block[R-1:R-8], last byte in block[7:0].
REQ-012 block_valid  output  1  block holds a complete block.
REQ-013 block_last  output  1  qualifies block_valid; final block of the message.
REQ-014 block_ready  input  1  downstream keccak accepts block when high with block_valid.

Function
REQ-015 SHALL implement FSM states FILL, PAD, EMIT.
- FILL: in_ready=1.
- PAD, EMIT: in_ready=0.
REQ-016 FILL, byte accepted: SHALL write the byte at index cnt and increment cnt (0..NB-1).
- cnt reaches NB: go to EMIT.
- in_last set and cnt<NB: go to PAD.
REQ-017 FILL, flush accepted: SHALL go to PAD. in_valid and flush together is illegal; in that case in_valid wins and flush is ignored.
REQ-018 PAD SHALL last exactly one cycle and then go to EMIT.
- Padding is written in that cycle: DOMAIN at index cnt, 8'h00 at later indices, 8'h80 ORed into index NB-1.
- If cnt=NB-1, the single pad byte is DOMAIN|8'h80 (8'h86).
REQ-019 Byte filling the last slot with in_last set (message end aligned to the block): SHALL go to EMIT with a pending-pad flag.
- After the handshake, go to PAD with cnt=0, producing a pure pad block 06 00..00 80.
REQ-020 EMIT: block_valid=1.
- block and block_last SHALL be held stable until block_valid && block_ready.
- Handshake: cnt cleared, block cleared to zero, next state PAD if pad pending, else FILL.
REQ-021 block_last=1 only on blocks that contain padding.
REQ-022 Latency, cycles from accept to block_valid:
- block completed by a data byte: 1 cycle.
- padded block: 2 cycles after in_last/flush accept.
REQ-023 block_ready asserted while block_valid=0 SHALL have no effect.
REQ-024 Padding SHALL apply only to the current message; the next message starts in FILL with cnt=0.

Reset
REQ-025 Reset asserted SHALL immediately force:
- state FILL, cnt=0, block=0, pad-pending=0;
- block_valid=0, block_last=0, in_ready=1 (after release).
REQ-026 Reset mid-fill or mid-EMIT SHALL discard the partial message; no block is emitted.

Configuration
REQ-027 Macro SHA3_PADDER_COUNT_EN.
- Defined: adds output msg_len[31:0], the count of data bytes accepted in the current message. It increments on each accepted byte and clears on the block_last handshake; it saturates at 32'hFFFFFFFF. Its reset value is 0.
- Undefined: no msg_len port and no counter logic; all other behaviour is identical.

Structure
REQ-028 Package sha3_pkg SHALL hold:
- the FSM state enum;
- constants PAD_SHA3=8'h06 and PAD_END=8'h80;
- function rate_bits(d) returning 1600-2*d.
REQ-029 Single module; no sub-module. The padded block output connects directly to the keccak message input.

Verification (D=256, NB=136)
REQ-030 Empty message (flush only) -> one block: block[1087:1080]=8'h06, block[7:0]=8'h80, all other bits 0, block_last=1, block_valid 2 cycles after flush.
REQ-031 "abc" (61 62 63, last on 63) -> block[1087:1056]=32'h61626306, block[7:0]=8'h80, block_last=1; SHA3-256 of the keccak output = 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
REQ-032 135 bytes, last on byte 135 -> one block, block[7:0]=8'h86, block_last=1.
REQ-033 136 bytes, last on byte 136 -> two blocks. Block 1 holds data only, block_last=0. Block 2 = 06,00..00,80 with block_last=1.
REQ-034 Hold block_ready low 5 cycles during EMIT -> block stable and in_ready=0 throughout; a 300-byte message yields 3 blocks with no byte lost or duplicated.
REQ-035 Assert reset after 50 bytes, then send "abc" -> no block from the first message; output matches REQ-031. With SHA3_PADDER_COUNT_EN, msg_len=3 before the final handshake.
